param_shift_serializer: RTL and testbench

PARAM_SHIFT_SERIALIZER -- requirements
Module: param_shift_serializer

---
 rtl/param_shift_serializer.sv | 102 ++++++++++
 tb/tb_param_shift_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/param_shift_serializer.sv
// Parallel-to-serial transmitter with a mirrored serial-to-parallel capture path.
// Frames are WIDTH bits long and may be streamed back-to-back without an idle gap.
module param_shift_serializer #(
    parameter int WIDTH     = 10,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             sIn,
    output logic             sOut,
    output logic             busy,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg, capsh;
    logic [WIDTH-1:0] shreg_adv, capsh_adv;
    logic             accept, last_shift;

    // Transmit moves toward the sOut end while receive enters from the opposite end.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_adv = {shreg[WIDTH-2:0], 1'b0};
            assign capsh_adv = {capsh[WIDTH-2:0], sIn};
        end else begin : g_lsb
            assign shreg_adv = {1'b0, shreg[WIDTH-1:1]};
            assign capsh_adv = {sIn, capsh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A load is also accepted on the completing edge of a frame, which keeps the stream gapless.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        sOut       = IDLE_BIT;
        last_shift = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                busy       = 1'b1;
                sOut       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                last_shift = shift_en && (cnt == LAST);
                load_ready = last_shift;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        accept = load_valid && load_ready;
        if (accept)
            state_next = SHIFT;
        else if (last_shift)
            state_next = IDLE;
    end

    always_ff @(posedge Clock) begin
        if (!rst) begin
            cnt       <= '0;
            shreg     <= '0;
            capsh     <= '0;
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= last_shift;
            if (last_shift)
                cap_data <= capsh_adv;
            if (state == SHIFT && shift_en)
                capsh <= capsh_adv;
            if (accept) begin
                shreg <= data;
                cnt   <= '0;
            end else if (state == SHIFT && shift_en) begin
                shreg <= shreg_adv;
                cnt   <= last_shift ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_param_shift_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus; expected
// serial bits and captured words are queued when driven and compared as they emerge.
module tb_param_shift_serializer;

    localparam int W = 10;
    localparam logic IDLE = 1'b0;

    logic         Clock;
    logic         rst;
    logic [W-1:0] data;
    logic         load_valid;
    logic         shift_en;
    logic         sIn;
    logic         load_ready_m, sOut_m, busy_m, cap_valid_m;
    logic         load_ready_l, sOut_l, busy_l, cap_valid_l;
    logic [W-1:0] cap_data_m, cap_data_l;

    int errors = 0;
    int checks = 0;

    logic         qm[$];
    logic         ql[$];
    logic         sinq[$];
    logic [W-1:0] capQm[$];
    logic [W-1:0] capQl[$];
    logic [W-1:0] expCapM = '0;
    logic [W-1:0] expCapL = '0;

    param_shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut (
        .Clock(Clock), .rst(rst), .data(data), .load_valid(load_valid),
        .load_ready(load_ready_m), .shift_en(shift_en), .sIn(sIn), .sOut(sOut_m),
        .busy(busy_m), .cap_data(cap_data_m), .cap_valid(cap_valid_m)
    );

    param_shift_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dutl (
        .Clock(Clock), .rst(rst), .data(data), .load_valid(load_valid),
        .load_ready(load_ready_l), .shift_en(shift_en), .sIn(sIn), .sOut(sOut_l),
        .busy(busy_l), .cap_data(cap_data_l), .cap_valid(cap_valid_l)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, updates the scoreboard for the coming edge, then checks outputs.
    task automatic applyStimulus(input logic lv, input logic [W-1:0] d, input logic se,
                                 input logic si, input logic r);
        logic expReady;
        logic completing;
        logic [W-1:0] wm, wl;
        rst = r; load_valid = lv; data = d; shift_en = se; sIn = si;
        #1;
        expReady = (qm.size() == 0) || (qm.size() == 1 && se);
        checkOutput("load_ready_m", {31'd0, load_ready_m}, {31'd0, expReady});
        checkOutput("load_ready_l", {31'd0, load_ready_l}, {31'd0, expReady});
        completing = 1'b0;
        if (!r) begin
            qm.delete(); ql.delete(); sinq.delete(); capQm.delete(); capQl.delete();
            expCapM = '0;
            expCapL = '0;
        end else begin
            if (se && qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                sinq.push_back(si);
                if (qm.size() == 0) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = sinq[i];
                        wl[i]     = sinq[i];
                    end
                    capQm.push_back(wm);
                    capQl.push_back(wl);
                    sinq.delete();
                    completing = 1'b1;
                end
            end
            if (lv && expReady) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(d[W-1-i]);
                    ql.push_back(d[i]);
                end
            end
        end
        @(posedge Clock);
        @(negedge Clock);
        checkOutput("busy_m", {31'd0, busy_m}, {31'd0, qm.size() != 0});
        checkOutput("busy_l", {31'd0, busy_l}, {31'd0, ql.size() != 0});
        checkOutput("sOut_m", {31'd0, sOut_m}, {31'd0, (qm.size() != 0) ? qm[0] : IDLE});
        checkOutput("sOut_l", {31'd0, sOut_l}, {31'd0, (ql.size() != 0) ? ql[0] : IDLE});
        checkOutput("cap_valid_m", {31'd0, cap_valid_m}, {31'd0, completing});
        checkOutput("cap_valid_l", {31'd0, cap_valid_l}, {31'd0, completing});
        if (completing) begin
            expCapM = capQm.pop_front();
            expCapL = capQl.pop_front();
        end
        checkOutput("cap_data_m", 32'(cap_data_m), 32'(expCapM));
        checkOutput("cap_data_l", 32'(cap_data_l), 32'(expCapL));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] word;
        word = 10'b1000010100;
        rst = 1'b0; load_valid = 1'b0; data = '0; shift_en = 1'b0; sIn = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] basic frame, sIn held high");
        applyStimulus(1'b1, word, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checkOutput("cap31_m", 32'(cap_data_m), 32'h3FF);
        checkOutput("cap31_l", 32'(cap_data_l), 32'h3FF);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("[TB] single-one sIn pattern");
        applyStimulus(1'b1, word, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, '0, 1'b1, (i == 0), 1'b1);
        checkOutput("cap32_l", 32'(cap_data_l), 32'h001);
        checkOutput("cap32_m", 32'(cap_data_m), 32'h200);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] stall after fourth bit");
        applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'(i), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'(i + 1), 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] back-to-back frames");
        applyStimulus(1'b1, 10'h2AA, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 10'h2AA, 1'b1, 1'(i), 1'b1);
        applyStimulus(1'b1, 10'h155, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, '0, 1'b1, 1'(i + 1), 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("[TB] load request mid-frame");
        applyStimulus(1'b1, word, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b1);
        checkOutput("ready_midframe", {31'd0, load_ready_m}, 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, word, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_cap_m", 32'(cap_data_m), 32'h0);
        checkOutput("abort_busy_m", {31'd0, busy_m}, 32'd0);
        applyStimulus(1'b1, 10'h2C3, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) applyStimulus(1'b0, '0, 1'b1, 1'(i), 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
